// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes, opcode constants and dispatch FSM states
package alu_pkg;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1001;
  localparam logic [3:0] ALU_SGT = 4'b1010;
  localparam logic [3:0] ALU_EQ  = 4'b1011;

  // Major opcodes understood by the dispatcher
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  // funct7 variants
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Dispatch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational instruction decode to ALU code (MUL gated by ALU_MUL_EN)
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] code,
  output logic       illegal
);

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // Map opcode/funct fields to an ALU code; anything unmapped stays NOP and is flagged illegal
  always_comb begin
    code    = ALU_NOP;
    illegal = 1'b1;
    if (opcode == OPC_OP && funct7 == F7_BASE) begin
      case (funct3)
        3'b000:  code = ALU_ADD;
        3'b001:  code = ALU_SLL;
        3'b010:  code = ALU_SLT;
        3'b101:  code = ALU_SRL;
        3'b110:  code = ALU_OR;
        3'b111:  code = ALU_AND;
        default: code = ALU_NOP;
      endcase
    end else if (opcode == OPC_OP && funct7 == F7_ALT && funct3 == 3'b000) begin
      code = ALU_SUB;
    end else if (opcode == OPC_OP && funct7 == F7_MULDIV && funct3 == 3'b000) begin
      code = MUL_EN ? ALU_MUL : ALU_NOP;
    end else if (opcode == OPC_CUSTOM0 && funct7 == F7_BASE) begin
      case (funct3)
        3'b000:  code = ALU_SGT;
        3'b001:  code = ALU_EQ;
        default: code = ALU_NOP;
      endcase
    end
    illegal = (code == ALU_NOP);
  end

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - single-issue ALU dispatcher with response handshake (ALU_MUL_EN enables MUL)
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int OP_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [OP_W-1:0]  in_rs1_val,
  input  logic [OP_W-1:0]  in_rs2_val,
  output logic [OP_W-1:0]  alu_operand_1,
  output logic [OP_W-1:0]  alu_operand_2,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_result,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dispatch_state_t  state_q, state_d;
  logic [OP_W-1:0]  rs1_q, rs1_d;
  logic [OP_W-1:0]  rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic [3:0]       code_q, code_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0]       dec_code;
  logic             dec_illegal;

  alu_decode u_decode (
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // Sequencer next state plus capture of request fields, ALU result and completion count
  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    code_d    = code_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rs1_d     = in_rs1_val;
          rs2_d     = in_rs2_val;
          rd_d      = in_rd;
          code_d    = dec_code;
          illegal_d = dec_illegal;
          if (dec_illegal) begin
            // Undecodable instructions never reach the ALU and answer with a zero result
            result_d = 32'd0;
            state_d  = RESP;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = CAPT;
      end
      CAPT: begin
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
          if (!illegal_q) begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers; reset drops any in-flight operation without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      code_q    <= ALU_NOP;
      illegal_q <= 1'b0;
      result_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      code_q    <= code_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      count_q   <= count_d;
    end
  end

  // Port drive: ALU sees a code only during ISSUE, and everything reads as reset while rst is high
  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_rd        = '0;
    out_result    = '0;
    out_illegal   = 1'b0;
    op_count      = '0;
    alu_control   = ALU_NOP;
    alu_operand_1 = '0;
    alu_operand_2 = '0;
    if (!rst) begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == RESP);
      out_rd      = rd_q;
      out_result  = result_q;
      out_illegal = illegal_q;
      op_count    = count_q;
      if (state_q == ISSUE) begin
        alu_control   = code_q;
        alu_operand_1 = rs1_q;
        alu_operand_2 = rs2_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - self-checking bench for alu_dispatch with a behavioural ALU peer
module tb_alu_dispatch;

  localparam int OP_W  = 5;
  localparam int CNT_W = 16;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_C0 = 7'b0001011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [6:0]      in_opcode = '0;
  logic [2:0]      in_funct3 = '0;
  logic [6:0]      in_funct7 = '0;
  logic [4:0]      in_rd = '0;
  logic [OP_W-1:0] in_rs1_val = '0;
  logic [OP_W-1:0] in_rs2_val = '0;
  logic            out_ready = 1'b0;

  logic             in_ready, out_valid, out_illegal;
  logic [OP_W-1:0]  alu_operand_1, alu_operand_2;
  logic [3:0]       alu_control;
  logic [31:0]      alu_result = '0;
  logic [4:0]       out_rd;
  logic [31:0]      out_result;
  logic [CNT_W-1:0] op_count;

  logic            w_in_ready, w_out_valid, w_out_illegal;
  logic [OP_W-1:0] w_op1, w_op2;
  logic [3:0]      w_alu_control;
  logic [31:0]     w_alu_result = '0;
  logic [4:0]      w_out_rd;
  logic [31:0]     w_out_result;
  logic [1:0]      w_op_count;

  always #5 clk = ~clk;

  alu_dispatch #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_control(alu_control), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_illegal(out_illegal), .op_count(op_count)
  );

  alu_dispatch #(.OP_W(OP_W), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_operand_1(w_op1), .alu_operand_2(w_op2),
    .alu_control(w_alu_control), .alu_result(w_alu_result),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_rd(w_out_rd),
    .out_result(w_out_result), .out_illegal(w_out_illegal), .op_count(w_op_count)
  );

  // Behavioural ALU semantics for each operation code
  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [OP_W-1:0] a,
                                          input logic [OP_W-1:0] b);
    logic signed [OP_W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (c)
      4'b0001: return 32'(a) + 32'(b);
      4'b0010: return 32'(a) - 32'(b);
      4'b0011: return 32'(a & b);
      4'b0100: return 32'(a) << b;
      4'b0101: return 32'(a) >> b;
      4'b0111: return 32'(a | b);
      4'b1000: return 32'(a) * 32'(b);
      4'b1001: return {31'd0, sa < sb};
      4'b1010: return {31'd0, sa > sb};
      4'b1011: return {31'd0, a == b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Registered ALU peers, one per dispatcher
  always @(posedge clk) begin
    alu_result   <= alu_ref(alu_control, alu_operand_1, alu_operand_2);
    w_alu_result <= alu_ref(w_alu_control, w_op1, w_op2);
  end

  int nz_cnt = 0;
  always @(negedge clk) if (alu_control != 4'b0000) nz_cnt++;

  typedef struct {
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
  } enc_t;
  enc_t encs[$];

  typedef struct {
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    int              stall;
    logic            ill;
    logic [31:0]     res;
    logic [3:0]      code;
  } vec_t;
  vec_t vecs[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_cnt = 0;

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [OP_W-1:0] a,
                              input logic [OP_W-1:0] b, input int stall, input logic ill,
                              input logic [31:0] res, input logic [3:0] code);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rd = rd; v.a = a; v.b = b;
    v.stall = stall; v.ill = ill; v.res = res; v.code = code;
    return v;
  endfunction

  function automatic void add_enc(input logic [6:0] opc, input logic [6:0] f7,
                                  input logic [2:0] f3, input logic [3:0] code);
    enc_t e;
    e.opc = opc; e.f7 = f7; e.f3 = f3; e.code = code;
    encs.push_back(e);
  endfunction

  // Reference decode: look the field triple up in the list of documented encodings
  function automatic void model_decode(input logic [6:0] opc, input logic [6:0] f7,
                                       input logic [2:0] f3, output logic ill,
                                       output logic [3:0] code);
    ill  = 1'b1;
    code = 4'b0000;
    foreach (encs[i]) begin
      if (encs[i].opc == opc && encs[i].f7 == f7 && encs[i].f3 == f3) begin
        ill  = 1'b0;
        code = encs[i].code;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_illegal"}, 32'(out_illegal), 32'd0);
    check({tag, "_out_rd"}, 32'(out_rd), 32'd0);
    check({tag, "_out_result"}, out_result, 32'd0);
    check({tag, "_alu_control"}, 32'(alu_control), 32'd0);
    check({tag, "_operand_1"}, 32'(alu_operand_1), 32'd0);
    check({tag, "_operand_2"}, 32'(alu_operand_2), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
    check({tag, "_op_count_w"}, 32'(w_op_count), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.opc; in_funct3 = v.f3; in_funct7 = v.f7; in_rd = v.rd;
    in_rs1_val = v.a; in_rs2_val = v.b;
    in_valid = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    int lat, nz0;
    wait_ready();
    nz0 = nz_cnt;
    drive(v);
    @(negedge clk);
    in_valid = 1'b0;
    in_rs1_val = '1;
    in_rs2_val = '1;
    lat = 1;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    if (!v.ill) begin
      check("issue_ctl", 32'(alu_control), 32'(v.code));
      check("issue_op1", 32'(alu_operand_1), 32'(v.a));
      check("issue_op2", 32'(alu_operand_2), 32'(v.b));
    end
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check(v.ill ? "latency_illegal" : "latency", 32'(lat), v.ill ? 32'd1 : 32'd3);
    check("resp_rd", 32'(out_rd), 32'(v.rd));
    check("resp_result", out_result, v.res);
    check("resp_illegal", 32'(out_illegal), 32'(v.ill));
    check("resp_ctl_idle", 32'(alu_control), 32'd0);
    check("resp_w_valid", 32'(w_out_valid), 32'(out_valid));
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_rd", 32'(out_rd), 32'(v.rd));
      check("hold_result", out_result, v.res);
      check("hold_illegal", 32'(out_illegal), 32'(v.ill));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    check("hs_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    if (!v.ill) exp_cnt = exp_cnt + 1;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_in_ready_w", 32'(w_in_ready), 32'd1);
    check("op_count", 32'(op_count), exp_cnt & 32'h0000_FFFF);
    check("op_count_w", 32'(w_op_count), exp_cnt & 32'd3);
    check("alu_issue_cycles", 32'(nz_cnt - nz0), v.ill ? 32'd0 : 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic ill;
    logic [3:0] code;
    int wrap_exp[5];
    int hung;

    add_enc(OPC_R,  7'b0000000, 3'b000, 4'b0001);
    add_enc(OPC_R,  7'b0000000, 3'b001, 4'b0100);
    add_enc(OPC_R,  7'b0000000, 3'b010, 4'b1001);
    add_enc(OPC_R,  7'b0000000, 3'b101, 4'b0101);
    add_enc(OPC_R,  7'b0000000, 3'b110, 4'b0111);
    add_enc(OPC_R,  7'b0000000, 3'b111, 4'b0011);
    add_enc(OPC_R,  7'b0100000, 3'b000, 4'b0010);
    add_enc(OPC_C0, 7'b0000000, 3'b000, 4'b1010);
    add_enc(OPC_C0, 7'b0000000, 3'b001, 4'b1011);
`ifdef ALU_MUL_EN
    add_enc(OPC_R,  7'b0000001, 3'b000, 4'b1000);
`endif

    vecs.push_back(mk(OPC_R,  3'b000, 7'b0000000, 5'd3,  5'd1,  5'h12, 0, 1'b0, 32'h13, 4'b0001));
    vecs.push_back(mk(OPC_R,  3'b000, 7'b0100000, 5'd7,  5'd5,  5'd2,  4, 1'b0, 32'd3,  4'b0010));
    vecs.push_back(mk(OPC_R,  3'b100, 7'b0000000, 5'd9,  5'd6,  5'd3,  1, 1'b1, 32'd0,  4'b0000));
`ifdef ALU_MUL_EN
    vecs.push_back(mk(OPC_R,  3'b000, 7'b0000001, 5'd4,  5'd3,  5'd7,  0, 1'b0, 32'd21, 4'b1000));
`else
    vecs.push_back(mk(OPC_R,  3'b000, 7'b0000001, 5'd4,  5'd3,  5'd7,  0, 1'b1, 32'd0,  4'b0000));
`endif
    vecs.push_back(mk(OPC_R,  3'b001, 7'b0000000, 5'd10, 5'd3,  5'd2,  0, 1'b0, 32'd12, 4'b0100));
    vecs.push_back(mk(OPC_R,  3'b101, 7'b0000000, 5'd11, 5'd20, 5'd2,  2, 1'b0, 32'd5,  4'b0101));
    vecs.push_back(mk(OPC_R,  3'b010, 7'b0000000, 5'd12, 5'd31, 5'd1,  0, 1'b0, 32'd1,  4'b1001));
    vecs.push_back(mk(OPC_C0, 3'b000, 7'b0000000, 5'd13, 5'd31, 5'd1,  0, 1'b0, 32'd0,  4'b1010));
    vecs.push_back(mk(OPC_C0, 3'b001, 7'b0000000, 5'd14, 5'd9,  5'd9,  1, 1'b0, 32'd1,  4'b1011));
    vecs.push_back(mk(OPC_R,  3'b110, 7'b0000000, 5'd15, 5'h0C, 5'h03, 0, 1'b0, 32'h0F, 4'b0111));
    vecs.push_back(mk(OPC_R,  3'b111, 7'b0000000, 5'd16, 5'h1C, 5'h0E, 0, 1'b0, 32'h0C, 4'b0011));
    vecs.push_back(mk(OPC_R,  3'b101, 7'b0100000, 5'd17, 5'd8,  5'd1,  0, 1'b1, 32'd0,  4'b0000));
    vecs.push_back(mk(OPC_C0, 3'b010, 7'b0000000, 5'd18, 5'd8,  5'd1,  0, 1'b1, 32'd0,  4'b0000));
    vecs.push_back(mk(7'b0010011, 3'b000, 7'b0000000, 5'd19, 5'd8, 5'd1, 0, 1'b1, 32'd0, 4'b0000));

    do_reset();
    foreach (vecs[i]) run_op(vecs[i]);

    // Reset while the operation sits in ISSUE: nothing may come back
    wait_ready();
    drive(vecs[0]);
    @(negedge clk);
    in_valid = 1'b0;
    check("midop_issue_ctl", 32'(alu_control), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midop_reset");
    rst = 1'b0;
    exp_cnt = 0;
    hung = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) hung++;
    end
    check("midop_no_response", 32'(hung), 32'd0);
    run_op(vecs[0]);

    // Two-bit counter wraps across five legal operations
    do_reset();
    wrap_exp = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[0]);
      check("wrap_seq", 32'(w_op_count), 32'(wrap_exp[i]));
    end

    // Randomised operations against the reference decode and ALU semantics
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        int k;
        k = $urandom_range(0, encs.size() - 1);
        v.opc = encs[k].opc; v.f7 = encs[k].f7; v.f3 = encs[k].f3;
      end else begin
        v.opc = ($urandom_range(0, 1) == 1) ? OPC_R : 7'($urandom);
        v.f7  = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'($urandom);
        v.f3  = 3'($urandom);
      end
      v.rd    = 5'($urandom);
      v.a     = OP_W'($urandom);
      v.b     = OP_W'($urandom);
      v.stall = $urandom_range(0, 2);
      model_decode(v.opc, v.f7, v.f3, ill, code);
      v.ill  = ill;
      v.code = code;
      v.res  = ill ? 32'd0 : alu_ref(code, v.a, v.b);
      run_op(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter OP_W, default 5, the ALU operand width.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the completed-operation counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the instruction request handshake.
REQ-006 SHALL have port in_opcode, input, 7, the RISC-V major opcode.
REQ-007 SHALL have port in_funct3, input, 3, the instruction funct3 field.
REQ-008 SHALL have port in_funct7, input, 7, the instruction funct7 field.
REQ-009 SHALL have port in_rd, input, 5, the destination register tag.
REQ-010 SHALL have ports in_rs1_val and in_rs2_val, input, OP_W each, the source operands.
REQ-011 SHALL have ports alu_operand_1 and alu_operand_2, output, OP_W each, driven to the ALU.
REQ-012 SHALL have port alu_control, output, 4, the ALU operation code.
REQ-013 SHALL have port alu_result, input, 32, the registered ALU result.
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the response handshake.
REQ-015 SHALL have port out_rd, output, 5, the destination tag of the response.
REQ-016 SHALL have port out_result, output, 32, the response result.
REQ-017 SHALL have port out_illegal, output, 1, set when the instruction is not decodable.
REQ-018 SHALL have port op_count, output, CNT_W, the count of completed legal operations.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, CAPT and RESP.
REQ-020 SHALL assert in_ready only in IDLE, and only when rst is low.
REQ-021 SHALL, in IDLE on in_valid, register the operands, in_rd and the decoded code.
REQ-022 SHALL, on a legal decode, transition IDLE->ISSUE.
REQ-023 SHALL, on an illegal decode, go IDLE->RESP with out_illegal=1 and out_result=0, with no ALU issue.
REQ-024 SHALL, in ISSUE, drive the registered alu_control and operands for exactly one cycle, then go to CAPT.
REQ-025 SHALL drive alu_control=4'b0000 and operands=0 in every state other than ISSUE.
REQ-026 SHALL, in CAPT, register alu_result into out_result, then go to RESP.
REQ-027 SHALL, in RESP, hold out_valid=1 with stable out_rd, out_result and out_illegal until out_ready.
REQ-028 SHALL, on the out_valid&&out_ready cycle, return to IDLE; no request is accepted in that same cycle.
REQ-029 SHALL therefore have latency 3 cycles from acceptance edge to out_valid, and peak throughput 1 op per 4 cycles.
REQ-030 SHALL decode opcode 0110011 with funct7=0000000 by funct3 as 000 ADD=0001, 001 SLL=0100, 010 SLT=1001, 101 SRL=0101, 110 OR=0111, 111 AND=0011.
REQ-031 SHALL decode opcode 0110011, funct7=0100000, funct3=000 as SUB=0010.
REQ-032 SHALL decode custom-0 opcode 0001011, funct7=0000000: funct3 000 as SGT=1010, 001 as EQ=1011.
REQ-033 SHALL treat every other combination as illegal.
REQ-034 SHALL increment op_count by 1 on each legal response handshake, wrapping from all-ones to 0.
REQ-035 SHALL NOT increment op_count for illegal responses.

Reset
REQ-036 SHALL, while rst is high, set state to IDLE and drive in_ready=0, out_valid=0, out_illegal=0, out_rd=0, out_result=0, alu_control=0, operands=0, op_count=0.
REQ-037 SHALL, on rst asserted in any state including mid-ISSUE or RESP, abandon the pending operation without producing a response.

Configuration
REQ-038 SHALL, with ALU_MUL_EN defined, decode opcode 0110011, funct7=0000001, funct3=000 as MUL=1000, counted as a legal op.
REQ-039 SHALL, without ALU_MUL_EN, treat that encoding as illegal.

Structure
REQ-040 SHALL place the 4-bit ALU code constants, the opcode constants and the FSM state enum in package alu_pkg, shared with the alu module.
REQ-041 SHALL implement decode as a combinational sub-module alu_decode: opcode, funct3, funct7 in; code and illegal out.

Verification
REQ-042 SHALL verify ADD: rs1=1, rs2=0x12, opcode 0110011/000/0000000, rd=3 -> out_valid 3 cycles after acceptance, out_result=0x13, out_rd=3, op_count=1.
REQ-043 SHALL verify SUB with backpressure: rs1=5, rs2=2, funct7=0100000, out_ready low 4 cycles -> outputs held stable, result=3, in_ready low until handshake.
REQ-044 SHALL verify an illegal op: funct3=100 (XOR) -> out_illegal=1, result=0, alu_control never nonzero, op_count unchanged.
REQ-045 SHALL verify MUL: rs1=3, rs2=7 -> result 21 with ALU_MUL_EN; out_illegal=1 without it.
REQ-046 SHALL verify reset mid-op: rst in ISSUE -> no response, all outputs at reset values next cycle, the next ADD completes normally.
REQ-047 SHALL verify wrap: CNT_W=2, five legal ops -> op_count sequence 1,2,3,0,1.
